// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a small receive FIFO behind a two-register Wishbone slave.
// RXDATA pops the head byte on read; STATUS reports {FERR, OVR, full, not-empty} with W1C flags.
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_rxd,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);

  // state | meaning
  // IDLE  | line idle, waiting for a low level on rx_s
  // START | counting to mid start bit, re-checking it is still low
  // DATA  | sampling 8 data bits mid-bit, LSB first
  // STOP  | sampling the stop bit; push byte or flag a framing error
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      CNT_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [2:0]       bitidx_q, bitidx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;

  logic push, push_ok, pop, full, empty, ferr_set, ovr_set;
  logic access, wr_status;
  logic [31:0] status;
  logic wb_dat_unused;

  assign wb_dat_unused = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

  always_comb begin
    rx_meta_d = i_rxd;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitidx_d  = bitidx_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    ferr_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rx_s_q) begin
          state_d  = DATA;
          cnt_d    = CNT_FULL;
          bitidx_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shreg_d  = {rx_s_q, shreg_q[7:1]};
          cnt_d    = CNT_FULL;
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          // Back to IDLE immediately so a start bit right after mid-stop is not missed.
          state_d  = IDLE;
          push     = rx_s_q;
          ferr_set = ~rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign status = {28'b0, ferr_q, ovr_q, full, ~empty};
  assign access = i_wb_cyc & ~ack_q;
  assign wr_status = access & i_wb_we & i_wb_adr;
  assign pop    = access & ~i_wb_we & ~i_wb_adr & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    ovr_d = ovr_q;
    if (ovr_set) ovr_d = 1'b1;
    else if (wr_status && i_wb_dat[2]) ovr_d = 1'b0;
    ferr_d = ferr_q;
    if (ferr_set) ferr_d = 1'b1;
    else if (wr_status && i_wb_dat[3]) ferr_d = 1'b0;

    ack_d = access;
    rdt_d = 32'b0;
    if (access && !i_wb_we) begin
      if (i_wb_adr)   rdt_d = status;
      else if (!empty) rdt_d = {24'b0, mem_q[rd_ptr_q]};
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bitidx_q  <= 3'd0;
      shreg_q   <= 8'd0;
      mem_q     <= '{default: 8'd0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdt_q     <= 32'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitidx_q  <= bitidx_d;
      shreg_q   <= shreg_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_irq    = ~empty;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
// All tasks start and end 1 time unit after a rising clock edge.
module tb_servant_uart_rx;

  localparam int CPB = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        i_rxd;
  logic        i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_irq;

  int n_cmp  = 0;
  int n_fail = 0;

  servant_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .i_rxd    (i_rxd),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .i_wb_we  (i_wb_we),
    .i_wb_cyc (i_wb_cyc),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .o_irq    (o_irq)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  // Returns at the end of the last stop-bit period; the byte is pushed on the next edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rxd = b[i];
      idle(CPB);
    end
    i_rxd = stop_bit;
    idle(CPB);
    i_rxd = 1'b1;
  endtask

  task automatic wb_read(input logic adr, output logic [31:0] data, output logic ack);
    i_wb_cyc = 1'b1;
    i_wb_we  = 1'b0;
    i_wb_adr = adr;
    idle(1);
    data = o_wb_rdt;
    ack  = o_wb_ack;
    i_wb_cyc = 1'b0;
    idle(1);
  endtask

  task automatic wb_write(input logic adr, input logic [31:0] data, output logic ack);
    i_wb_cyc = 1'b1;
    i_wb_we  = 1'b1;
    i_wb_adr = adr;
    i_wb_dat = data;
    idle(1);
    ack = o_wb_ack;
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    i_wb_dat = 32'h0;
    idle(1);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic a;
    idle(3);
    n_cmp++;
    if (o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b exp 0", o_wb_ack); end
    n_cmp++;
    if (o_wb_rdt !== 32'h0) begin n_fail++; $display("FAIL rst_rdt got %h exp 0", o_wb_rdt); end
    n_cmp++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b exp 0", o_irq); end
    wb_rst = 1'b0;
    idle(2);
    wb_read(1'b1, d, a);
    n_cmp++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL rst_status_ack got %b exp 1", a); end
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status got %h exp 0", d); end
  endtask

  task automatic test_single_byte;
    logic [31:0] d;
    logic a;
    send_byte(8'hA5, 1'b1);
    @(negedge wb_clk);
    n_cmp++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_push got %b exp 0", o_irq); end
    @(negedge wb_clk);
    n_cmp++;
    if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_push got %b exp 1", o_irq); end
    idle(1);
    wb_read(1'b0, d, a);
    n_cmp++;
    if (d !== 32'h000000A5) begin n_fail++; $display("FAIL rx_a5 got %h exp 000000a5", d); end
    n_cmp++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_read got %b exp 0", o_irq); end
    n_cmp++;
    if (o_wb_rdt !== 32'h0) begin n_fail++; $display("FAIL rdt_idle got %h exp 0", o_wb_rdt); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic a;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(4);
    wb_read(1'b0, d, a);
    n_cmp++;
    if (d !== 32'h00) begin n_fail++; $display("FAIL b2b_first got %h exp 0", d); end
    n_cmp++;
    if (o_irq !== 1'b1) begin n_fail++; $display("FAIL b2b_irq got %b exp 1", o_irq); end
    wb_read(1'b0, d, a);
    n_cmp++;
    if (d !== 32'hFF) begin n_fail++; $display("FAIL b2b_second got %h exp ff", d); end
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL b2b_status got %h exp 0", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    logic a;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    idle(4);
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h7) begin n_fail++; $display("FAIL ovr_status got %h exp 7", d); end
    for (int i = 1; i <= 4; i++) begin
      wb_read(1'b0, d, a);
      n_cmp++;
      if (d !== 32'(i)) begin n_fail++; $display("FAIL ovr_read%0d got %h exp %h", i, d, 32'(i)); end
    end
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL ovr_status_empty got %h exp 4", d); end
    wb_write(1'b1, 32'h4, a);
    n_cmp++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL ovr_clr_ack got %b exp 1", a); end
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_cleared got %h exp 0", d); end
  endtask

  task automatic test_framing;
    logic [31:0] d;
    logic a;
    send_byte(8'h55, 1'b0);
    idle(12);
    n_cmp++;
    if (o_irq !== 1'b0) begin n_fail++; $display("FAIL ferr_irq got %b exp 0", o_irq); end
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL ferr_status got %h exp 8", d); end
    wb_write(1'b1, 32'h8, a);
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_cleared got %h exp 0", d); end
    i_rxd = 1'b0;
    idle(1);
    i_rxd = 1'b1;
    idle(20);
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_status got %h exp 0", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    logic a;
    i_rxd = 1'b0;
    idle(CPB);
    i_rxd = 1'b1;
    idle(CPB);
    i_rxd = 1'b0;
    idle(CPB);
    wb_rst = 1'b1;
    i_rxd  = 1'b1;
    idle(2);
    wb_rst = 1'b0;
    idle(4);
    send_byte(8'h3C, 1'b1);
    idle(4);
    wb_read(1'b0, d, a);
    n_cmp++;
    if (d !== 32'h3C) begin n_fail++; $display("FAIL rstmid_byte got %h exp 3c", d); end
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_status got %h exp 0", d); end
  endtask

  task automatic test_push_pop_full;
    logic [31:0] d;
    logic a;
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
    idle(4);
    send_byte(8'h15, 1'b1);
    wb_read(1'b0, d, a);
    n_cmp++;
    if (d !== 32'h11) begin n_fail++; $display("FAIL pp_pop got %h exp 11", d); end
    wb_read(1'b1, d, a);
    n_cmp++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL pp_status got %h exp 3", d); end
    for (int i = 0; i < 4; i++) begin
      wb_read(1'b0, d, a);
      n_cmp++;
      if (d !== 32'h12 + 32'(i)) begin
        n_fail++; $display("FAIL pp_order%0d got %h exp %h", i, d, 32'h12 + 32'(i));
      end
    end
    wb_read(1'b0, d, a);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL empty_read got %h exp 0", d); end
    n_cmp++;
    if (a !== 1'b1) begin n_fail++; $display("FAIL empty_ack got %b exp 1", a); end
  endtask

  initial begin
    wb_rst   = 1'b1;
    i_rxd    = 1'b1;
    i_wb_adr = 1'b0;
    i_wb_dat = 32'h0;
    i_wb_we  = 1'b0;
    i_wb_cyc = 1'b0;
    #1;
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_overrun;
    test_framing;
    test_reset_mid_frame;
    test_push_pop_full;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
